// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NCH independent programmable clock dividers.
//
// Each channel divides clk by 2*max(H,1) and produces a 50% duty clk_out.
// A new half-period is captured with div_load and held pending until the
// next clk_out rising toggle. If the channel is stopped, the pending value
// is applied on the following cycle instead. div_ack pulses in the cycle
// the new value becomes active.
//
// Parameters
//   NCH       number of channels (1..8)
//   CW        counter / half-period width
//   DEF_HALF  half-period loaded into every channel at reset
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   en        [NCH]     per-channel run enable
//   div_half  [NCH*CW]  requested half-period, channel i at [i*CW +: CW]
//   div_load  [NCH]     one-cycle capture strobe for div_half
//   div_ack   [NCH]     one-cycle pulse when a new half-period takes effect
//   clk_out   [NCH]     registered divided clock
//   tick      [NCH]     one-cycle pulse with each clk_out rise
//
// Build option
//   CLK_DIV_BANK_TICK_EN  when defined, tick is generated; otherwise tick
//                         is tied to 0 and has no registers behind it.

module clk_div_chan #(
  parameter int unsigned CW       = 32,
  parameter int unsigned DEF_HALF = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic [CW-1:0] half,
  output logic          ack,
  output logic          clk_out,
  output logic          tick
);
  localparam logic [CW-1:0] DEF_H = CW'(DEF_HALF);

  logic [CW-1:0] ha;    // active half-period
  logic [CW-1:0] hp;    // pending half-period
  logic          pf;    // pending flag
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;  // terminal count, HA of 0 treated as 1
  logic          wrap;
  logic          rise;
  logic          apply;

  assign last  = (ha == '0) ? '0 : ha - 1'b1;
  assign wrap  = en && (cnt == last);
  assign rise  = wrap && !clk_out;
  // Running channels only switch on a rising boundary so a period is never
  // cut short or stretched; stopped channels switch right away.
  assign apply = pf && (en ? rise : 1'b1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ha      <= DEF_H;
      hp      <= DEF_H;
      pf      <= 1'b0;
      cnt     <= '0;
      clk_out <= 1'b0;
      ack     <= 1'b0;
    end else begin
      if (!en) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
      end else begin
        cnt     <= cnt + 1'b1;
      end

      ack <= apply;
      if (apply) begin
        ha <= hp;
        pf <= 1'b0;
      end
      // A load on an apply boundary lands after the old HP was consumed,
      // so it simply becomes the next pending value.
      if (load) begin
        hp <= half;
        pf <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_BANK_TICK_EN
  logic tick_q;
  always_ff @(posedge clk) begin
    if (reset) tick_q <= 1'b0;
    else       tick_q <= rise;
  end
  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

module clk_div_bank #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned CW       = 32,
  parameter int unsigned DEF_HALF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*CW-1:0] div_half,
  input  logic [NCH-1:0]    div_load,
  output logic [NCH-1:0]    div_ack,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_chan #(
      .CW       (CW),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .en      (en[i]),
      .load    (div_load[i]),
      .half    (div_half[i*CW +: CW]),
      .ack     (div_ack[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. The reference model schedules
// clk_out toggles as absolute cycle timestamps (next toggle = last toggle +
// effective half-period) rather than counting, and checks every output on
// every cycle, plus directed period checks measured from clk_out rises.

module tb_clk_div_bank;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int DEF = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] div_half;
  logic [NCH-1:0]    div_load;
  logic [NCH-1:0]    div_ack;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;

  clk_div_bank #(.NCH(NCH), .CW(CW), .DEF_HALF(DEF)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .div_half (div_half),
    .div_load (div_load),
    .div_ack  (div_ack),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // reference model state
  longint cyc = 0;
  int     m_ha [NCH];
  int     m_hp [NCH];
  bit     m_pf [NCH];
  bit     m_run[NCH];
  bit     m_out[NCH];
  longint m_nt [NCH];
  logic [NCH-1:0] m_ack, m_tick, m_clk;

  // observed-period tracking
  longint last_rise[NCH];
  int     per[NCH];
  bit     rose[NCH];
  logic [NCH-1:0] prev_out = '0;

  function automatic int eff(int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    cyc++;
    m_ack  = '0;
    m_tick = '0;
    for (int c = 0; c < NCH; c++) begin
      int v;
      v = int'(div_half[c*CW +: CW]);
      if (reset) begin
        m_ha[c] = DEF; m_hp[c] = DEF; m_pf[c] = 0;
        m_out[c] = 0;  m_run[c] = 0;
      end else if (!en[c]) begin
        m_out[c] = 0; m_run[c] = 0;
        if (m_pf[c]) begin m_ha[c] = m_hp[c]; m_pf[c] = 0; m_ack[c] = 1'b1; end
        if (div_load[c]) begin m_hp[c] = v; m_pf[c] = 1; end
      end else begin
        if (!m_run[c]) begin
          m_run[c] = 1;
          m_nt[c]  = cyc + eff(m_ha[c]) - 1;
        end
        if (cyc == m_nt[c]) begin
          m_out[c] = !m_out[c];
          if (m_out[c]) begin
            m_tick[c] = 1'b1;
            if (m_pf[c]) begin m_ha[c] = m_hp[c]; m_pf[c] = 0; m_ack[c] = 1'b1; end
          end
          m_nt[c] = cyc + eff(m_ha[c]);
        end
        if (div_load[c]) begin m_hp[c] = v; m_pf[c] = 1; end
      end
      m_clk[c] = m_out[c];
    end
  endtask

  task automatic check_all();
    logic [NCH-1:0] exp_tick;
`ifdef CLK_DIV_BANK_TICK_EN
    exp_tick = m_tick;
`else
    exp_tick = '0;
`endif
    chk("clk_out", 32'(clk_out), 32'(m_clk));
    chk("div_ack", 32'(div_ack), 32'(m_ack));
    chk("tick",    32'(tick),    32'(exp_tick));
    for (int c = 0; c < NCH; c++) begin
      rose[c] = clk_out[c] && !prev_out[c];
      if (rose[c]) begin
        if (last_rise[c] >= 0) per[c] = int'(cyc - last_rise[c]);
        last_rise[c] = cyc;
      end
    end
    prev_out = clk_out;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_half(int c, int v);
    div_half[c*CW +: CW] = CW'(v);
  endtask

  task automatic load1(int c, int v);
    set_half(c, v);
    div_load[c] = 1'b1;
    step();
    div_load[c] = 1'b0;
  endtask

  task automatic wait_rise(int c);
    bit found;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (rose[c]) found = 1;
    end
    chk("wait_rise", 32'(found), 32'd1);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) begin
      last_rise[c] = -1; per[c] = 0; m_nt[c] = 0;
      m_ha[c] = DEF; m_hp[c] = DEF; m_pf[c] = 0; m_run[c] = 0; m_out[c] = 0;
    end
    reset    = 1'b1;
    en       = '1;
    div_half = '0;
    div_load = '0;

    // reset held 3 cycles with enables high: everything stays 0
    run(3);
    chk("reset_clk_out", 32'(clk_out), 32'd0);
    chk("reset_ack",     32'(div_ack), 32'd0);
    reset = 1'b0;
    run(8);
    chk("def_period_ch1", 32'(per[1]), 32'd2);

    // channel 0: load 5 while stopped, ack the next cycle
    en[0] = 1'b0;
    step();
    load1(0, 5);
    step();
    chk("ack_stopped", 32'(div_ack[0]), 32'd1);
    en[0] = 1'b1;
    run(25);
    chk("period_h5", 32'(per[0]), 32'd10);

    // load 3 two cycles into a high phase: current period still 10
    wait_rise(0);
    step();
    load1(0, 3);
    wait_rise(0);
    chk("period_before_apply", 32'(per[0]), 32'd10);
    chk("ack_on_rise",         32'(div_ack[0]), 32'd1);
    run(14);
    chk("period_h3", 32'(per[0]), 32'd6);

    // two loads before application: last wins, single ack
    load1(0, 2);
    step();
    load1(0, 4);
    run(30);
    chk("period_h4", 32'(per[0]), 32'd8);

    // half-period 0 behaves as 1
    en[0] = 1'b0;
    load1(0, 0);
    step();
    en[0] = 1'b1;
    run(12);
    chk("period_h0", 32'(per[0]), 32'd2);

    // drop en0 mid-high phase; channel 1 keeps its period
    en[0] = 1'b0;
    load1(0, 5);
    step();
    en[0] = 1'b1;
    wait_rise(0);
    step();
    en[0] = 1'b0;
    step();
    chk("stop_clk_out0", 32'(clk_out[0]), 32'd0);
    run(6);
    chk("indep_period_ch1", 32'(per[1]), 32'd2);
    en[0] = 1'b1;
    run(20);

    // randomized traffic on all channels
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
        div_load[c] = ($urandom_range(0, 11) == 0);
        set_half(c, int'($urandom_range(0, 6)));
      end
      step();
    end
    reset    = 1'b0;
    div_load = '0;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 2: number of independent divider channels, range 1..8.
REQ-002 Parameter CW, default 32: counter and half-period width in bits.
REQ-003 Parameter DEF_HALF, default 1: half-period, in clk cycles, loaded into every channel at reset.
REQ-004 clk  input  1: single system clock; all logic on its rising edge.
REQ-005 reset  input  1: reset, synchronous and active-high.
REQ-006 en  input  NCH: per-channel run enable.
REQ-007 div_half  input  NCH*CW: per-channel requested half-period, channel i at bits [i*CW +: CW].
REQ-008 div_load  input  NCH: per-channel one-cycle load request; captures div_half slice.
REQ-009 div_ack  output  NCH: one-cycle pulse when the requested half-period takes effect.
REQ-010 clk_out  output  NCH: registered divided clock per channel.
REQ-011 tick  output  NCH: one-cycle pulse on the cycle clk_out rises (see Configuration).

Function
REQ-012 Each channel SHALL hold active half-period HA, pending half-period HP, pending flag PF, counter CNT, and clk_out register.
REQ-013 Effective half-period SHALL be max(HA,1); a value of 0 SHALL behave exactly as 1.
REQ-014 While en[i]=1 and CNT != HA_eff-1: CNT increments by 1 per cycle and clk_out holds.
REQ-015 While en[i]=1 and CNT == HA_eff-1: CNT wraps to 0 and clk_out toggles in the same cycle.
REQ-016 Resulting clk_out period SHALL be 2*HA_eff clk cycles at 50% duty; first rising edge HA_eff cycles after en goes high from a stopped state.
REQ-017 While en[i]=0: CNT forced to 0, clk_out forced to 0 next cycle, tick 0.
REQ-018 div_load[i]=1 SHALL capture the div_half slice into HP and set PF; a second load before application overwrites HP with no extra ack.
REQ-019 With en[i]=1, a pending value SHALL be applied (HA<=HP, PF<=0) only in the cycle clk_out toggles 0->1, so no period is ever truncated or stretched mid-period.
REQ-020 With en[i]=0, a pending value SHALL be applied in the cycle after capture.
REQ-021 div_ack[i] SHALL pulse high exactly in the cycle HA takes the new value, once per application.
REQ-022 div_load in the same cycle as an application boundary: the old HP is applied and acked; the new value becomes pending.
REQ-023 Channels SHALL be fully independent; no cross-channel state.

Reset
REQ-024 On reset=1 at a clk edge: HA=HP=DEF_HALF, PF=0, CNT=0, clk_out=0, tick=0, div_ack=0 for all channels.
REQ-025 Reset SHALL override en and div_load in the same cycle; a pending load is discarded without ack.

Configuration
REQ-026 Macro CLK_DIV_BANK_TICK_EN: when defined, tick[i] SHALL be high for exactly the cycle clk_out[i] is first high after a 0->1 toggle.
REQ-027 Without CLK_DIV_BANK_TICK_EN: tick port remains present and is driven constant 0; no tick registers.

Verification
REQ-028 Reset held 3 cycles, en=2'b11 -> all outputs 0 during reset; HA=DEF_HALF=1 so clk_out toggles every cycle (period 2) afterwards.
REQ-029 Channel 0 div_half=5, load while en=0, then en=1 -> div_ack pulse 1 cycle after load; clk_out0 rises after 5 cycles, period 10, high 5 / low 5.
REQ-030 Channel 0 running H=5, load H=3 on cycle 2 of high phase -> current period finishes at 10 cycles; ack coincides with next rise; following periods are 6 cycles.
REQ-031 div_half=0 loaded -> identical behaviour to H=1 (period 2).
REQ-032 en0 dropped mid-high phase -> clk_out0=0 next cycle, CNT=0; channel 1 unaffected, period unchanged.
REQ-033 With CLK_DIV_BANK_TICK_EN, H=4 -> tick pulses once every 8 cycles, aligned to clk_out rise; without the macro tick stays 0.
